darkbusarb: RTL and testbench

DARKBUSARB -- requirements
Module: darkbusarb

---
 rtl/darkbusarb_if.sv | 60 ++++++
 rtl/darkbusarb.sv | 122 ++++++++++++
 tb/tb_darkbusarb.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/darkbusarb_if.sv
// darkbusarb_if: two-master request bus plus slave bus of darkbusarb.
// master = arbiter view, slave = environment view. ERR: DARKBUSARB_TIMEOUT_EN.
interface darkbusarb_if;
  logic        M0_REQ;
  logic        M1_REQ;
  logic        M0_WE;
  logic        M1_WE;
  logic [31:0] M0_ADDR;
  logic [31:0] M1_ADDR;
  logic [31:0] M0_WDATA;
  logic [31:0] M1_WDATA;
  logic [31:0] M0_RDATA;
  logic [31:0] M1_RDATA;
  logic        M0_ACK;
  logic        M1_ACK;
`ifdef DARKBUSARB_TIMEOUT_EN
  logic        M0_ERR;
  logic        M1_ERR;
`endif
  logic        S_EN;
  logic        S_RE;
  logic        S_WE;
  logic [31:0] S_ADDR;
  logic [31:0] S_WDATA;
  logic [31:0] S_RDATA;
  logic        S_RACK;
  logic        S_WACK;

  modport master (
    input  M0_REQ, M1_REQ,
    input  M0_WE, M1_WE,
    input  M0_ADDR, M1_ADDR,
    input  M0_WDATA, M1_WDATA,
    output M0_RDATA, M1_RDATA,
    output M0_ACK, M1_ACK,
`ifdef DARKBUSARB_TIMEOUT_EN
    output M0_ERR, M1_ERR,
`endif
    output S_EN, S_RE, S_WE,
    output S_ADDR, S_WDATA,
    input  S_RDATA,
    input  S_RACK, S_WACK
  );

  modport slave (
    output M0_REQ, M1_REQ,
    output M0_WE, M1_WE,
    output M0_ADDR, M1_ADDR,
    output M0_WDATA, M1_WDATA,
    input  M0_RDATA, M1_RDATA,
    input  M0_ACK, M1_ACK,
`ifdef DARKBUSARB_TIMEOUT_EN
    input  M0_ERR, M1_ERR,
`endif
    input  S_EN, S_RE, S_WE,
    input  S_ADDR, S_WDATA,
    output S_RDATA,
    output S_RACK, S_WACK
  );
endinterface

// File: rtl/darkbusarb.sv
// darkbusarb: round-robin arbiter, M0 (ifetch) / M1 (data) onto one slave.
// Ports: XCLK, XRES (sync, active-low), bus (darkbusarb_if.master).
// Macro DARKBUSARB_TIMEOUT_EN adds the ack watchdog and ERR pulses.
module darkbusarb #(
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input logic          XCLK,
  input logic          XRES,
  darkbusarb_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic        last_gnt;
  logic        gnt;
  logic        we_q;

  logic        any_req;
  logic        win;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        s_ack;

  assign any_req = bus.M0_REQ | bus.M1_REQ;
  // Tie goes to the master not granted last; 1 selects M1.
  assign win = (bus.M0_REQ & bus.M1_REQ) ? ~last_gnt : bus.M1_REQ;
  assign win_we    = win ? bus.M1_WE    : bus.M0_WE;
  assign win_addr  = win ? bus.M1_ADDR  : bus.M0_ADDR;
  assign win_wdata = win ? bus.M1_WDATA : bus.M0_WDATA;
  // Either strobe ends the transfer; read data is taken only for reads.
  assign s_ack = bus.S_RACK | bus.S_WACK;

`ifdef DARKBUSARB_TIMEOUT_EN
  logic [3:0] wd_cnt;
  logic       wd_hit;
  assign wd_hit = (wd_cnt + 4'd1) == TIMEOUT;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge XCLK) begin
    if (!XRES) begin
      state        <= IDLE;
      last_gnt     <= 1'b1;
      gnt          <= 1'b0;
      we_q         <= 1'b0;
      bus.S_EN     <= 1'b0;
      bus.S_RE     <= 1'b0;
      bus.S_WE     <= 1'b0;
      bus.S_ADDR   <= '0;
      bus.S_WDATA  <= '0;
      bus.M0_RDATA <= '0;
      bus.M1_RDATA <= '0;
      bus.M0_ACK   <= 1'b0;
      bus.M1_ACK   <= 1'b0;
`ifdef DARKBUSARB_TIMEOUT_EN
      bus.M0_ERR   <= 1'b0;
      bus.M1_ERR   <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      bus.M0_ACK <= 1'b0;
      bus.M1_ACK <= 1'b0;
`ifdef DARKBUSARB_TIMEOUT_EN
      bus.M0_ERR <= 1'b0;
      bus.M1_ERR <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt         <= win;
            last_gnt    <= win;
            we_q        <= win_we;
            bus.S_ADDR  <= win_addr;
            bus.S_WDATA <= win_wdata;
            bus.S_EN    <= 1'b1;
            bus.S_RE    <= ~win_we;
            bus.S_WE    <= win_we;
            state       <= BUSY;
`ifdef DARKBUSARB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
          end
        end
        BUSY: begin
          if (s_ack) begin
            if (!we_q) begin
              if (gnt) bus.M1_RDATA <= bus.S_RDATA;
              else     bus.M0_RDATA <= bus.S_RDATA;
            end
            if (gnt) bus.M1_ACK <= 1'b1;
            else     bus.M0_ACK <= 1'b1;
            bus.S_EN <= 1'b0;
            bus.S_RE <= 1'b0;
            bus.S_WE <= 1'b0;
            state    <= DONE;
          end
`ifdef DARKBUSARB_TIMEOUT_EN
          else if (wd_hit) begin
            if (gnt) bus.M1_ERR <= 1'b1;
            else     bus.M0_ERR <= 1'b1;
            bus.S_EN <= 1'b0;
            bus.S_RE <= 1'b0;
            bus.S_WE <= 1'b0;
            state    <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 4'd1;
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_darkbusarb.sv
// tb_darkbusarb: directed vector table plus corner sequences.
// Slave model acks after a per-vector delay.
module tb_darkbusarb;

  logic XCLK = 1'b0;
  logic XRES;
  always #5 XCLK = ~XCLK;

  darkbusarb_if bif ();

  darkbusarb dut (
    .XCLK (XCLK),
    .XRES (XRES),
    .bus  (bif)
  );

  int errors = 0;
  int checks = 0;

  logic auto_ack = 1'b0;
  logic both_ack = 1'b0;
  logic spur     = 1'b0;
  int   dly      = 0;
  int   wcnt     = 0;
  logic rack_q   = 1'b0;
  logic wack_q   = 1'b0;

  assign bif.S_RACK = rack_q | spur;
  assign bif.S_WACK = wack_q | spur;

  always @(posedge XCLK) begin
    rack_q <= 1'b0;
    wack_q <= 1'b0;
    if (!bif.S_EN) begin
      wcnt <= 0;
    end else if (auto_ack && !(rack_q || wack_q)) begin
      if (wcnt == dly) begin
        rack_q <= both_ack | bif.S_RE;
        wack_q <= both_ack | bif.S_WE;
        wcnt   <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1, sd;
    int          dl;
    logic        both, drop, g;
    logic [31:0] x0, x1;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic r0, input logic r1);
    bif.M0_REQ = r0;
    bif.M1_REQ = r1;
  endtask

  task automatic run(input vec_t v);
    logic        ew, er, ng, hold_ok;
    logic [31:0] ea, ed;
    int          lat;
    ew = v.g ? v.w1 : v.w0;
    er = !ew;
    ng = !v.g;
    ea = v.g ? v.a1 : v.a0;
    ed = v.g ? v.d1 : v.d0;
    @(negedge XCLK);
    set_req(v.r0, v.r1);
    bif.M0_WE    = v.w0;
    bif.M1_WE    = v.w1;
    bif.M0_ADDR  = v.a0;
    bif.M1_ADDR  = v.a1;
    bif.M0_WDATA = v.d0;
    bif.M1_WDATA = v.d1;
    bif.S_RDATA  = v.sd;
    dly      = v.dl;
    both_ack = v.both;
    auto_ack = 1'b1;
    @(posedge XCLK); #1;
    chk("grant_en", bif.S_EN, 1);
    chk("grant_we", bif.S_WE, ew);
    chk("grant_re", bif.S_RE, er);
    chk("grant_addr", bif.S_ADDR, ea);
    chk("grant_wdata", bif.S_WDATA, ed);
    if (v.drop) begin
      @(negedge XCLK);
      set_req(1'b0, 1'b0);
    end
    lat = 0;
    hold_ok = 1'b1;
    while (!(bif.M0_ACK | bif.M1_ACK) && lat < 30) begin
      @(posedge XCLK); #1;
      lat++;
      if (!(bif.M0_ACK | bif.M1_ACK))
        if (!bif.S_EN || bif.S_ADDR !== ea) hold_ok = 1'b0;
    end
    chk("hold", hold_ok, 1);
    chk("latency", lat, v.dl + 2);
    chk("ack0", bif.M0_ACK, ng);
    chk("ack1", bif.M1_ACK, v.g);
    chk("rdata0", bif.M0_RDATA, v.x0);
    chk("rdata1", bif.M1_RDATA, v.x1);
    chk("en_off", bif.S_EN, 0);
`ifdef DARKBUSARB_TIMEOUT_EN
    chk("no_err", bif.M0_ERR | bif.M1_ERR, 0);
`endif
    @(posedge XCLK); #1;
    chk("ack_pulse", bif.M0_ACK | bif.M1_ACK, 0);
    chk("done_idle", bif.S_EN, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    bit quiet;
    int n;
    //        r0 r1 w0 w1 a0 a1 d0 d1 sd dl both drop g x0 x1
    tv[0] = '{1,1,0,0,32'h10,32'h14,32'h0,32'h0,
              32'h13,0,0,0,0,32'h13,32'h0};
    tv[1] = '{1,1,0,0,32'h20,32'h24,32'h1,32'h2,
              32'hA1,0,0,0,1,32'h13,32'hA1};
    tv[2] = '{1,1,0,0,32'h30,32'h34,32'h3,32'h4,
              32'hA2,1,0,0,0,32'hA2,32'hA1};
    tv[3] = '{1,1,0,0,32'h38,32'h3C,32'h5,32'h6,
              32'hA3,0,0,0,1,32'hA2,32'hA3};
    tv[4] = '{0,1,0,1,32'h0,32'h800,32'h0,32'hDEADBEEF,
              32'hFFFFFFFF,0,1,0,1,32'hA2,32'hA3};
    tv[5] = '{0,1,0,0,32'h0,32'h40,32'h0,32'h7,
              32'hB5,3,0,0,1,32'hA2,32'hB5};
    tv[6] = '{1,0,1,0,32'h100,32'h0,32'h12345678,32'h0,
              32'hEEEE,0,0,0,0,32'hA2,32'hB5};
    tv[7] = '{1,0,0,0,32'h10,32'h0,32'h8,32'h0,
              32'h13,2,0,1,0,32'h13,32'hB5};
    tv[8] = '{1,1,1,0,32'h200,32'h44,32'h77,32'h9,
              32'hC8,0,1,0,1,32'h13,32'hC8};
    tv[9] = '{1,1,0,0,32'h50,32'h54,32'hA,32'hB,
              32'hD9,0,0,0,0,32'hD9,32'h0};
    tv[10] = '{0,1,0,0,32'h0,32'h58,32'h0,32'hC,
              32'hE1,0,0,0,1,32'hD9,32'hE1};

    XRES = 1'b0;
    set_req(1'b1, 1'b1);
    bif.M0_WE = 1'b0;
    bif.M1_WE = 1'b0;
    bif.M0_ADDR = 32'h1234;
    bif.M1_ADDR = 32'h5678;
    bif.M0_WDATA = 32'h1;
    bif.M1_WDATA = 32'h2;
    bif.S_RDATA = 32'h0;
    repeat (3) @(posedge XCLK);
    #1;
    chk("rst_en", bif.S_EN, 0);
    chk("rst_re_we", {bif.S_RE, bif.S_WE}, 0);
    chk("rst_ack", {bif.M0_ACK, bif.M1_ACK}, 0);
    chk("rst_addr", bif.S_ADDR, 0);
    chk("rst_wdata", bif.S_WDATA, 0);
    chk("rst_rdata0", bif.M0_RDATA, 0);
    chk("rst_rdata1", bif.M1_RDATA, 0);
    @(negedge XCLK);
    set_req(1'b0, 1'b0);
    XRES = 1'b1;

    for (int i = 0; i < 9; i++) run(tv[i]);

    // Spurious acks in IDLE with no requests.
    @(negedge XCLK);
    set_req(1'b0, 1'b0);
    auto_ack = 1'b0;
    spur = 1'b1;
    repeat (2) @(posedge XCLK);
    #1;
    chk("spur_ack", {bif.M0_ACK, bif.M1_ACK}, 0);
    chk("spur_en", bif.S_EN, 0);
    chk("spur_rdata0", bif.M0_RDATA, 32'h13);
    chk("spur_rdata1", bif.M1_RDATA, 32'hC8);
    @(negedge XCLK);
    spur = 1'b0;

    // Reset in the middle of a transfer.
    set_req(1'b1, 1'b0);
    bif.M0_WE = 1'b0;
    bif.M0_ADDR = 32'h60;
    @(posedge XCLK); #1;
    chk("mid_busy_en", bif.S_EN, 1);
    @(negedge XCLK);
    XRES = 1'b0;
    set_req(1'b0, 1'b0);
    @(posedge XCLK); #1;
    chk("mid_rst_en", bif.S_EN, 0);
    chk("mid_rst_ack", {bif.M0_ACK, bif.M1_ACK}, 0);
    chk("mid_rst_rdata0", bif.M0_RDATA, 0);
    @(negedge XCLK);
    XRES = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge XCLK); #1;
      if (bif.M0_ACK | bif.M1_ACK | bif.S_EN) quiet = 1'b0;
    end
    chk("mid_rst_quiet", quiet, 1);

    // Pointer back at M1 after reset: tie goes to M0.
    run(tv[9]);

`ifdef DARKBUSARB_TIMEOUT_EN
    @(negedge XCLK);
    auto_ack = 1'b0;
    set_req(1'b1, 1'b0);
    bif.M0_WE = 1'b0;
    bif.M0_ADDR = 32'h70;
    @(posedge XCLK); #1;
    chk("wd_grant", bif.S_EN, 1);
    n = 0;
    quiet = 1'b1;
    while (!bif.M0_ERR && n < 40) begin
      @(posedge XCLK); #1;
      n++;
      if (bif.M0_ACK | bif.M1_ERR) quiet = 1'b0;
    end
    chk("wd_cycles", n, 15);
    chk("wd_no_ack", quiet, 1);
    chk("wd_en_off", bif.S_EN, 0);
    @(negedge XCLK);
    set_req(1'b0, 1'b0);
    @(posedge XCLK); #1;
    chk("wd_err_pulse", bif.M0_ERR, 0);
`else
    n = 0;
`endif

    run(tv[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
